pkt_emitter: RTL

PKT_EMITTER -- requirements
Module: pkt_emitter

---
 rtl/pkt_emitter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pkt_emitter.sv
// Per-packet metadata gate: forwards packets whose drop flag is clear through a
// 2-entry output FIFO, discards the rest, and counts forwarded/dropped/framing errors.
module pkt_emitter #(
  parameter int DATA_W   = 512,
  parameter int EMPTY_W  = 6,
  parameter int META_W   = 128,
  parameter int DROP_BIT = 0
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [META_W-1:0]  in_meta_data,
  input  logic               in_meta_valid,
  output logic               in_meta_ready,
  input  logic [DATA_W-1:0]  in_pkt_data,
  input  logic               in_pkt_valid,
  output logic               in_pkt_ready,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  output logic [DATA_W-1:0]  out_pkt_data,
  output logic               out_pkt_valid,
  input  logic               out_pkt_ready,
  output logic               out_pkt_sop,
  output logic               out_pkt_eop,
  output logic [EMPTY_W-1:0] out_pkt_empty,
  output logic [31:0]        stats_out_pkt,
  output logic [31:0]        stats_drop_pkt,
  output logic [31:0]        stats_err
);

  localparam int ENT_W = DATA_W + 2 + EMPTY_W;

  typedef enum logic [1:0] {IDLE, FWD, DISCARD} state_t;

  state_t           state;
  logic             first;
  logic [ENT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic meta_fire;
  logic pkt_fire;
  logic lead_bad;
  logic push;
  logic pop;
  logic unused_meta;

  assign unused_meta   = ^in_meta_data;
  assign in_meta_ready = (state == IDLE);

  always_comb begin
    in_pkt_ready = 1'b0;
    case (state)
      FWD:     in_pkt_ready = (count < 2'd2);
      DISCARD: in_pkt_ready = 1'b1;
      default: in_pkt_ready = 1'b0;
    endcase
  end

  assign meta_fire = in_meta_valid & in_meta_ready;
  assign pkt_fire  = in_pkt_valid & in_pkt_ready;
  // A leading flit without sop is swallowed; the packet has not started yet.
  assign lead_bad  = first & ~in_pkt_sop;
  assign push      = pkt_fire & (state == FWD) & ~lead_bad;
  assign pop       = out_pkt_valid & out_pkt_ready;

  assign out_pkt_valid = (count != 2'd0);
  assign {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty} = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= IDLE;
      first          <= 1'b0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= '0;
      stats_out_pkt  <= '0;
      stats_drop_pkt <= '0;
      stats_err      <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop && out_pkt_eop) stats_out_pkt <= stats_out_pkt + 32'd1;

      case (state)
        IDLE: begin
          if (meta_fire) begin
            state <= in_meta_data[DROP_BIT] ? DISCARD : FWD;
            first <= 1'b1;
          end
        end
        FWD, DISCARD: begin
          if (pkt_fire) begin
            if (lead_bad) begin
              stats_err <= stats_err + 32'd1;
            end else begin
              if (!first && in_pkt_sop) stats_err <= stats_err + 32'd1;
              first <= 1'b0;
              if (in_pkt_eop) begin
                state <= IDLE;
                if (state == DISCARD) stats_drop_pkt <= stats_drop_pkt + 32'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
